// File: rtl/diagonal_move_serializer.sv
// rtl/diagonal_move_serializer.sv - walks diagonal sliders and emits one (from, to, capture) move per handshake
module diagonal_move_serializer #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [63:0]        pieces,
   input  logic [63:0]        own,
   input  logic [63:0]        occupied,
   output logic [2:0]         atk_file,
   output logic [2:0]         atk_rank,
   output logic [63:0]        atk_occupied,
   input  logic [63:0]        attack_in,
   output logic               busy,
   output logic               move_valid,
   input  logic               move_ready,
   output logic [5:0]         move_from,
   output logic [5:0]         move_to,
   output logic               move_capture,
   output logic               done,
   output logic [COUNT_W-1:0] move_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_ATTACK,
      S_EMIT,
      S_DONE
   } state_t;

   state_t      state;
   logic [63:0] pieces_r;
   logic [63:0] own_r;
   logic [63:0] targets_r;
   logic [5:0]  sel_sq;

   // Index of the lowest set bit; 0 for an empty board.
   function automatic logic [5:0] lowest_bit(input logic [63:0] v);
      logic [5:0] idx;
      idx = '0;
      for (int i = 63; i >= 0; i--) begin
         if (v[i]) idx = 6'(i);
      end
      return idx;
   endfunction

   // Next slider square and the current move target, both from registered bitboards.
   always_comb begin
      sel_sq       = lowest_bit(pieces_r);
      move_to      = lowest_bit(targets_r);
      move_capture = atk_occupied[move_to];
      move_valid   = (state == S_EMIT) && (targets_r != '0);
   end

   // Scan state machine: one slider at a time, one target per accepted handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         atk_file     <= '0;
         atk_rank     <= '0;
         atk_occupied <= '0;
         move_from    <= '0;
         move_count   <= '0;
         pieces_r     <= '0;
         own_r        <= '0;
         targets_r    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  pieces_r     <= pieces;
                  own_r        <= own;
                  atk_occupied <= occupied;
                  move_count   <= '0;
                  busy         <= 1'b1;
                  state        <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (pieces_r == '0) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  atk_file <= sel_sq[2:0];
                  atk_rank <= sel_sq[5:3];
                  pieces_r <= pieces_r & (pieces_r - 64'd1);
                  state    <= S_ATTACK;
               end
            end
            S_ATTACK: begin
               // attack_in now reflects the registered file/rank/occupancy.
               targets_r <= attack_in & ~own_r;
               move_from <= {atk_rank, atk_file};
               state     <= S_EMIT;
            end
            S_EMIT: begin
               if (targets_r == '0) begin
                  state <= S_SELECT;
               end else if (move_ready) begin
                  targets_r <= targets_r & (targets_r - 64'd1);
                  if (move_count != '1) move_count <= move_count + 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diagonal_move_serializer.sv
// tb/tb_diagonal_move_serializer.sv - self-checking bench for diagonal_move_serializer
module tb_diagonal_move_serializer;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, start, move_ready;
   logic [63:0]   pieces, own, occupied, attack_in, atk_occupied;
   logic [2:0]    atk_file, atk_rank;
   logic          busy, move_valid, move_capture, done;
   logic [5:0]    move_from, move_to;
   logic [CW-1:0] move_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [12:0] exp_q[$];
   logic [12:0] got_q[$];
   int          slider_cnt;
   int          c1_to[7] = '{9, 11, 16, 20, 29, 38, 47};

   always #5 clk = ~clk;

   `define CHK(tag, obs, exp) begin n_cmp++; assert ((obs) === (exp)) else begin n_err++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

   // Sliding diagonal attacks: walk each of the four rays until the edge or a blocker.
   function automatic logic [63:0] diag_attacks(input int f, input int r, input logic [63:0] occ);
      logic [63:0] a;
      int dfs[4] = '{1, -1, 1, -1};
      int drs[4] = '{1, 1, -1, -1};
      int cf, cr;
      a = '0;
      for (int d = 0; d < 4; d++) begin
         cf = f + dfs[d];
         cr = r + drs[d];
         while (cf >= 0 && cf < 8 && cr >= 0 && cr < 8) begin
            a[cr*8+cf] = 1'b1;
            if (occ[cr*8+cf]) break;
            cf += dfs[d];
            cr += drs[d];
         end
      end
      return a;
   endfunction

   assign attack_in = diag_attacks(int'(atk_file), int'(atk_rank), atk_occupied);

   diagonal_move_serializer #(.COUNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .pieces(pieces), .own(own), .occupied(occupied),
      .atk_file(atk_file), .atk_rank(atk_rank), .atk_occupied(atk_occupied),
      .attack_in(attack_in), .busy(busy), .move_valid(move_valid),
      .move_ready(move_ready), .move_from(move_from), .move_to(move_to),
      .move_capture(move_capture), .done(done), .move_count(move_count)
   );

   task automatic build_expected(input logic [63:0] p, input logic [63:0] o, input logic [63:0] oc);
      logic [63:0] t;
      exp_q.delete();
      slider_cnt = 0;
      for (int sq = 0; sq < 64; sq++) begin
         if (p[sq]) begin
            slider_cnt++;
            t = diag_attacks(sq % 8, sq / 8, oc) & ~o;
            for (int x = 0; x < 64; x++)
               if (t[x]) exp_q.push_back({6'(sq), 6'(x), oc[x]});
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      `CHK({tag, ".busy"}, busy, 1'b0)
      `CHK({tag, ".move_valid"}, move_valid, 1'b0)
      `CHK({tag, ".done"}, done, 1'b0)
      `CHK({tag, ".atk_file_rank"}, {atk_rank, atk_file}, 6'd0)
      `CHK({tag, ".atk_occupied"}, atk_occupied, 64'd0)
      `CHK({tag, ".move"}, {move_from, move_to, move_capture}, 13'd0)
      `CHK({tag, ".move_count"}, move_count, {CW{1'b0}})
   endtask

   task automatic run_scan(input logic [63:0] p, input logic [63:0] o, input logic [63:0] oc,
                           input int ready_pct, input int stall_first, input int abort_after,
                           input string name);
      int          k, stalls, stall_rem, exp_done_k, n;
      bit          finished, prev_held;
      logic [12:0] prev_mv;
      logic [CW-1:0] exp_cnt;
      build_expected(p, o, oc);
      got_q.delete();
      @(negedge clk);
      pieces = p; own = o; occupied = oc; start = 1'b1;
      @(posedge clk);
      k = 0; stalls = 0; stall_rem = stall_first; finished = 0; prev_held = 0; prev_mv = '0;
      while (!finished) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            `CHK({name, ".busy_after_start"}, busy, 1'b1)
            `CHK({name, ".latched_occ"}, atk_occupied, oc)
            `CHK({name, ".select_no_valid"}, move_valid, 1'b0)
            // start is still high here (ignored while busy); scramble the inputs too.
            pieces = {$urandom, $urandom}; own = {$urandom, $urandom}; occupied = {$urandom, $urandom};
         end
         if (k == 2) start = 1'b0;
         if (prev_held) begin
            `CHK({name, ".held_valid"}, move_valid, 1'b1)
            `CHK({name, ".held_move"}, {move_from, move_to, move_capture}, prev_mv)
         end
         if (done) begin
            exp_done_k = 2 + 3 * slider_cnt + exp_q.size() + stalls;
            n = exp_q.size();
            exp_cnt = (n > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(n);
            `CHK({name, ".done_latency"}, k, exp_done_k)
            `CHK({name, ".busy_in_done"}, busy, 1'b1)
            `CHK({name, ".count_at_done"}, move_count, exp_cnt)
            @(posedge clk);
            @(negedge clk);
            `CHK({name, ".done_one_cycle"}, done, 1'b0)
            `CHK({name, ".busy_after_done"}, busy, 1'b0)
            `CHK({name, ".count_held"}, move_count, exp_cnt)
            finished = 1;
         end else if (abort_after >= 0 && got_q.size() == abort_after && move_valid) begin
            reset = 1'b1; move_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            check_reset_values({name, ".mid_reset"});
            @(posedge clk);
            @(negedge clk);
            `CHK({name, ".no_done_after_reset"}, done, 1'b0)
            finished = 1;
         end else begin
            if (stall_rem > 0 && move_valid) begin
               move_ready = 1'b0;
               stall_rem--;
            end else begin
               move_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (move_valid && move_ready) got_q.push_back({move_from, move_to, move_capture});
            if (move_valid && !move_ready) stalls++;
            prev_held = move_valid && !move_ready;
            prev_mv = {move_from, move_to, move_capture};
         end
         if (!finished && k > 4000) begin
            n_cmp++; n_err++;
            $error("FAIL %s.timeout observed=%0d cycles expected=done", name, k);
            finished = 1;
         end
      end
      start = 1'b0;
      if (abort_after >= 0) begin
         `CHK({name, ".accepts_before_reset"}, got_q.size(), abort_after)
      end else begin
         `CHK({name, ".move_total"}, got_q.size(), exp_q.size())
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         `CHK($sformatf("%s.move%0d", name, i), got_q[i], exp_q[i])
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; move_ready = 1'b0;
      pieces = '0; own = '0; occupied = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("por");
      reset = 1'b0;

      run_scan(64'h4, 64'h4, 64'h4, 100, 0, -1, "c1");
      `CHK("c1.count_moves", got_q.size(), 7)
      for (int i = 0; i < got_q.size() && i < 7; i++)
         `CHK($sformatf("c1.literal%0d", i), got_q[i], {6'd2, 6'(c1_to[i]), 1'b0})

      run_scan(64'h4, 64'h804, 64'hA04, 100, 0, -1, "blocked");
      `CHK("blocked.literal", got_q.size() > 0 ? got_q[0] : 13'h1FFF, {6'd2, 6'd9, 1'b1})

      run_scan(64'h0, 64'h0, 64'h0, 100, 0, -1, "empty");

      run_scan(64'h81, 64'h81, 64'h81, 100, 0, -1, "a1h1");

      run_scan(64'h4, 64'h4, 64'h4, 100, 3, -1, "backpressure");

      run_scan(64'h4, 64'h4, 64'h4, 100, 0, 3, "abort");
      run_scan(64'h4, 64'h4, 64'h4, 100, 0, -1, "after_abort");

      for (int s = 0; s < 10; s++) begin
         logic [63:0] rp, ro, roc;
         rp  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         ro  = rp | ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
         roc = ro | ({$urandom, $urandom} & {$urandom, $urandom});
         run_scan(rp, ro, roc, 60 + 4 * s, s % 3, -1, $sformatf("rand%0d", s));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
